layer_input_loader: RTL and testbench

LAYER_INPUT_LOADER -- requirements
Module: layer_input_loader

---
 rtl/layer_input_loader.sv | 93 +++++++++
 tb/tb_layer_input_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/layer_input_loader.sv
// Serial-to-parallel loader feeding a dense layer: collects NUM_INPUTS samples,
// strobes inputs_ready once, then waits for a fresh completion from the layer.

module layer_input_lane #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q
);
   always_ff @(posedge clock or negedge reset)
      if (!reset)  q <= '0;
      else if (we) q <= d;
endmodule

module layer_input_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_INPUTS = 16
) (
   input  logic                                        clock,
   input  logic                                        reset,
   input  logic                                        in_valid,
   input  logic signed [DATA_WIDTH-1:0]                in_data,
   output logic                                        in_ready,
   input  logic                                        outputs_ready,
   output logic signed [NUM_INPUTS-1:0][DATA_WIDTH-1:0] inputs,
   output logic                                        inputs_ready,
   output logic [$clog2(NUM_INPUTS+1)-1:0]             load_count
);
   localparam int CW = $clog2(NUM_INPUTS+1);

   typedef enum logic [1:0] {LOAD, ISSUE, WAIT} state_t;

   state_t state;
   logic   low_seen;
   logic   transfer;
   logic   last;

   assign transfer = in_valid && in_ready;
   assign last     = (load_count == CW'(NUM_INPUTS-1));

   // Each lane latches only on the transfer that targets its slot, so values
   // persist across vectors until overwritten.
   for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
      layer_input_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
         .clock (clock),
         .reset (reset),
         .we    (transfer && (load_count == CW'(g))),
         .d     (in_data),
         .q     (inputs[g])
      );
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= LOAD;
         load_count   <= '0;
         in_ready     <= 1'b1;
         inputs_ready <= 1'b0;
         low_seen     <= 1'b0;
      end else begin
         case (state)
            LOAD: if (transfer) begin
               load_count <= load_count + 1'b1;
               if (last) begin
                  state        <= ISSUE;
                  in_ready     <= 1'b0;
                  inputs_ready <= 1'b1;
               end
            end
            ISSUE: begin
               state        <= WAIT;
               inputs_ready <= 1'b0;
               low_seen     <= 1'b0;
            end
            WAIT: begin
               // A completion held high from the previous vector must drop first.
               if (outputs_ready && low_seen) begin
                  state      <= LOAD;
                  in_ready   <= 1'b1;
                  load_count <= '0;
                  low_seen   <= 1'b0;
               end else if (!outputs_ready) begin
                  low_seen <= 1'b1;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_layer_input_loader.sv
// Bench for layer_input_loader (DATA_WIDTH=8, NUM_INPUTS=4): directed table,
// corner sequences and random traffic checked against a vector-level model.

module tb_layer_input_loader;
   localparam int DW = 8;
   localparam int N  = 4;

   logic                       clock = 1'b0;
   logic                       reset = 1'b0;
   logic                       in_valid = 1'b0;
   logic signed [DW-1:0]       in_data = '0;
   logic                       in_ready;
   logic                       outputs_ready = 1'b0;
   logic signed [N-1:0][DW-1:0] inputs;
   logic                       inputs_ready;
   logic [2:0]                 load_count;

   layer_input_loader #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) dut (
      .clock         (clock),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .outputs_ready (outputs_ready),
      .inputs        (inputs),
      .inputs_ready  (inputs_ready),
      .load_count    (load_count)
   );

   always #5 clock = ~clock;

   int errs   = 0;
   int checks = 0;
   int pulses = 0;

   // Model: a vector is "filling" while fewer than N samples are held; once
   // full, age counts edges spent full (age 0 is the strobe cycle).
   logic [N-1:0][DW-1:0] m_vec;
   int                   m_cnt;
   int                   m_age;
   bit                   m_low;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_vec = '0; m_cnt = 0; m_age = 0; m_low = 0;
   endtask

   task automatic model_step(input logic v, input logic [DW-1:0] d, input logic o);
      if (m_cnt < N) begin
         if (v) begin
            m_vec[m_cnt] = d;
            m_cnt++;
            m_age = 0;
         end
      end else if (m_age == 0) begin
         m_age = 1;
         m_low = 0;
      end else if (o && m_low) begin
         m_cnt = 0;
      end else if (!o) begin
         m_low = 1;
      end
   endtask

   task automatic check_model();
      chk("in_ready",     32'(in_ready),     32'(m_cnt < N));
      chk("inputs_ready", 32'(inputs_ready), 32'(m_cnt == N && m_age == 0));
      chk("load_count",   32'(load_count),   32'(m_cnt));
      chk("inputs",       32'(inputs),       32'(m_vec));
      if (inputs_ready) pulses++;
   endtask

   task automatic cyc(input logic v, input logic [DW-1:0] d, input logic o);
      in_valid = v; in_data = d; outputs_ready = o;
      @(posedge clock);
      model_step(v, d, o);
      @(negedge clock);
      check_model();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      chk("async_inputs",     32'(inputs),       32'h0);
      chk("async_load_count", 32'(load_count),   32'h0);
      chk("async_irdy",       32'(inputs_ready), 32'h0);
      chk("async_in_ready",   32'(in_ready),     32'h1);
      @(negedge clock);
      reset = 1'b1;
   endtask

   typedef struct {
      logic          v;
      logic [DW-1:0] d;
      logic          o;
      logic          e_rdy;
      logic          e_irdy;
      logic [2:0]    e_cnt;
   } vec_t;

   vec_t tbl[7];

   initial begin
      tbl[0] = '{1'b1, 8'd5,   1'b0, 1'b1, 1'b0, 3'd1};
      tbl[1] = '{1'b1, 8'hFD,  1'b0, 1'b1, 1'b0, 3'd2};
      tbl[2] = '{1'b1, 8'd7,   1'b0, 1'b1, 1'b0, 3'd3};
      tbl[3] = '{1'b1, 8'd1,   1'b0, 1'b0, 1'b1, 3'd4};
      tbl[4] = '{1'b1, 8'd9,   1'b0, 1'b0, 1'b0, 3'd4};
      tbl[5] = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 3'd4};
      tbl[6] = '{1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 3'd0};

      model_reset();
      @(negedge clock);
      @(negedge clock);
      check_model();
      @(negedge clock);
      reset = 1'b1;

      // Back-to-back load, then release
      for (int i = 0; i < 7; i++) begin
         cyc(tbl[i].v, tbl[i].d, tbl[i].o);
         chk($sformatf("tbl%0d_in_ready", i),     32'(in_ready),     32'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_inputs_ready", i), 32'(inputs_ready), 32'(tbl[i].e_irdy));
         chk($sformatf("tbl%0d_load_count", i),   32'(load_count),   32'(tbl[i].e_cnt));
         if (i == 3) chk("b2b_inputs", 32'(inputs), 32'h01_07_FD_05);
      end

      // Gapped load
      begin
         logic       gv[7];
         logic [2:0] gc[7];
         int         k;
         gv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
         gc = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4};
         k = 0;
         for (int i = 0; i < 7; i++) begin
            cyc(gv[i], gv[i] ? 8'(10 * (k + 1)) : 8'hEE, 1'b0);
            if (gv[i]) k++;
            chk($sformatf("gap%0d_load_count", i), 32'(load_count), 32'(gc[i]));
         end
         chk("gap_inputs", 32'(inputs), 32'h28_1E_14_0A);
         cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 1);
      end

      // Stale completion held high through ISSUE
      for (int i = 0; i < 4; i++) cyc(1, 8'(i + 50), 1);
      cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 1);
      chk("stale_hold", 32'(in_ready), 32'h0);
      cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
      chk("stale_low_hold", 32'(in_ready), 32'h0);
      cyc(0, 0, 1);
      chk("stale_release_rdy", 32'(in_ready),   32'h1);
      chk("stale_release_cnt", 32'(load_count), 32'h0);

      // Source backpressure during WAIT
      for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 0);
      cyc(1, 8'd99, 0); cyc(1, 8'd99, 0); cyc(1, 8'd99, 0);
      chk("bp_wait_inputs", 32'(inputs), 32'h04_03_02_01);
      cyc(1, 8'd99, 1);
      chk("bp_release_inputs", 32'(inputs), 32'h04_03_02_01);
      cyc(1, 8'd99, 0);
      chk("bp_first_inputs", 32'(inputs), 32'h04_03_02_63);
      chk("bp_first_cnt", 32'(load_count), 32'h1);

      // Reset mid-load
      do_reset();
      cyc(1, 8'd5, 0); cyc(1, 8'd6, 0);
      do_reset();
      pulses = 0;
      for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 0);
      cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
      chk("rst_inputs", 32'(inputs), 32'h04_03_02_01);
      chk("rst_pulses", 32'(pulses), 32'h1);
      cyc(0, 0, 1);

      // Vector reuse
      pulses = 0;
      for (int i = 0; i < 4; i++) cyc(1, 8'd8, 0);
      cyc(0, 0, 0); cyc(0, 0, 0);
      chk("reuse_inputs", 32'(inputs), 32'h08_08_08_08);
      chk("reuse_pulses", 32'(pulses), 32'h1);
      cyc(0, 0, 1);

      // Random traffic with occasional resets in any phase
      begin
         logic o;
         o = 1'b0;
         for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) o = ~o;
            cyc(1'($urandom_range(0, 1)), 8'($urandom), o);
         end
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
